// File: rtl/dice_roll_controller.sv
// dice_roll_controller
//   Turns a debounced push-button into a dice roll for the eight_dice decoder.
//   While the button is held the face spins at a fixed rate. After release it
//   tumbles through SLOW_STEPS decelerating steps, each twice as long as the
//   one before, and then settles on a face.
// Ports:
//   clk     - single clock, rising edge
//   rst_n   - synchronous active-low reset
//   roll    - button level, asynchronous to clk, already debounced
//   s       - 3-bit face select to eight_dice
//   rolling - high while spinning or tumbling
//   done    - one-cycle pulse on the first cycle the final face is shown
module dice_roll_controller #(
  parameter int SPIN_DIV   = 4,
  parameter int SLOW_BASE  = 8,
  parameter int SLOW_STEPS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       roll,
  output logic [2:0] s,
  output logic       rolling,
  output logic       done
);

  localparam int STEP_W = (SLOW_STEPS > 1) ? $clog2(SLOW_STEPS) : 1;
  localparam logic [15:0]       SPIN_LAST = 16'(SPIN_DIV - 1);
  localparam logic [15:0]       SLOW_LEN0 = 16'(SLOW_BASE);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SLOW_STEPS - 1);

  typedef enum logic [1:0] {IDLE, SPIN, SLOW} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [15:0]       tick_q, tick_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [2:0]        face_q, face_d;
  logic              rolling_q, rolling_d;
  logic              done_q, done_d;
  logic [15:0]       slow_len;

  // Each decelerating step is twice as long as the previous one.
  assign slow_len = SLOW_LEN0 << step_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    step_d  = step_q;
    face_d  = face_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = SPIN;
          tick_d  = '0;
        end
      end
      SPIN: begin
        // Release wins over a coinciding advance.
        if (!sync2_q) begin
          state_d = SLOW;
          tick_d  = '0;
          step_d  = '0;
        end else if (tick_q == SPIN_LAST) begin
          face_d = face_q + 3'd1;
          tick_d = '0;
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      SLOW: begin
        // Re-grab wins over a coinciding step completion and suppresses done.
        if (sync2_q) begin
          state_d = SPIN;
          tick_d  = '0;
          step_d  = '0;
        end else if (tick_q == slow_len - 16'd1) begin
          face_d = face_q + 3'd1;
          tick_d = '0;
          if (step_q == LAST_STEP) begin
            state_d = IDLE;
            step_d  = '0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        step_d  = '0;
      end
    endcase
    rolling_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      tick_q    <= '0;
      step_q    <= '0;
      face_q    <= '0;
      rolling_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync1_q   <= roll;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      step_q    <= step_d;
      face_q    <= face_d;
      rolling_q <= rolling_d;
      done_q    <= done_d;
    end
  end

  assign s       = face_q;
  assign rolling = rolling_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Testbench for dice_roll_controller. Expected outputs on every edge are
// derived from the roll timeline: spin face = entry face + cycles/SPIN_DIV,
// tumble face = release face + number of cumulative step lengths elapsed.
module tb_dice_roll_controller;
  localparam int SD    = 4;
  localparam int SB    = 8;
  localparam int SN    = 4;
  localparam int TOTAL = SB * ((1 << SN) - 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       roll = 1'b0;
  logic [2:0] s;
  logic       rolling;
  logic       done;

  int checks = 0;
  int errors = 0;
  int mface  = 0;

  always #5 clk = ~clk;

  dice_roll_controller #(.SPIN_DIV(SD), .SLOW_BASE(SB), .SLOW_STEPS(SN)) dut (
    .clk(clk), .rst_n(rst_n), .roll(roll), .s(s), .rolling(rolling), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Tumble steps completed by tumble offset t (t=0 is the release edge).
  function automatic int slow_adv(input int t);
    int n = 0;
    for (int k = 1; k <= SN; k++)
      if (SB * ((1 << k) - 1) <= t) n++;
    return n;
  endfunction

  function automatic logic roll_lvl(input int e, input int r, input int g, input int r2);
    return (e >= 1 && e <= r) || (g > 0 && e >= r + 1 + g && e <= r + g + r2);
  endfunction

  // One roll: button held r edges; optional re-grab at tumble cycle g held r2
  // edges; optional reset at tumble cycle rst_at of the first tumble.
  task automatic press(input int r, input int g, input int r2, input int rst_at);
    int f0, fr1, f2, fr2, e1, rl1, e2, rl2, re, last, t, es, er, ed, dones;
    f0  = mface;
    e1  = 3;
    rl1 = e1 + r;
    fr1 = f0 + (r - 1) / SD;
    e2  = (g > 0) ? rl1 + g : 0;
    rl2 = e2 + r2;
    f2  = fr1 + ((g > 0) ? slow_adv(g - 1) : 0);
    fr2 = f2 + ((r2 > 0) ? (r2 - 1) / SD : 0);
    re  = (rst_at > 0) ? rl1 + rst_at : 0;
    last = (re > 0) ? re + 4 : (((g > 0) ? rl2 : rl1) + TOTAL + 3);
    dones = 0;
    roll  = roll_lvl(1, r, g, r2);
    rst_n = 1'b1;
    for (int e = 1; e <= last; e++) begin
      @(posedge clk); #1;
      ed = 0;
      if (re > 0 && e >= re) begin
        es = 0; er = 0;
      end else if (e < e1) begin
        es = f0; er = 0;
      end else if (e < rl1) begin
        es = f0 + (e - e1) / SD; er = 1;
      end else if (g == 0 || e < e2) begin
        t = e - rl1; es = fr1 + slow_adv(t); er = (t < TOTAL); ed = (t == TOTAL);
      end else if (e < rl2) begin
        es = f2 + (e - e2) / SD; er = 1;
      end else begin
        t = e - rl2; es = fr2 + slow_adv(t); er = (t < TOTAL); ed = (t == TOTAL);
      end
      chk($sformatf("s@%0d", e), s, es % 8);
      chk($sformatf("rolling@%0d", e), rolling, er);
      chk($sformatf("done@%0d", e), done, ed);
      if (done === 1'b1) dones++;
      roll  = roll_lvl(e + 1, r, g, r2);
      rst_n = !(re > 0 && e + 1 >= re && e + 1 < re + 2);
    end
    chk("done_count", dones, (re > 0) ? 0 : 1);
    mface = (re > 0) ? 0 : (((g > 0) ? fr2 : fr1) + SN) % 8;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_s", s, 0);
      chk("rst_rolling", rolling, 0);
    end
    rst_n = 1'b1;
    mface = 0;
  endtask

  initial begin
    int r, g, r2;
    // Reset held with the button pressed, then released with button low.
    rst_n = 1'b0;
    roll  = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("reset_s", s, 0);
      chk("reset_rolling", rolling, 0);
      chk("reset_done", done, 0);
    end
    rst_n = 1'b1;
    roll  = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("post_reset_s", s, 0);
      chk("post_reset_rolling", rolling, 0);
      chk("post_reset_done", done, 0);
    end

    // Basic roll: 2 spin advances, then +4.
    press(10, 0, 0, 0);
    chk("basic_final", s, 6);

    // Re-grab 20 cycles into the tumble.
    press(5, 20, 6, 0);

    // Reset in the middle of the tumble aborts without done.
    press(7, 0, 0, 50);
    chk("midslow_final", s, 0);

    // Minimal press from face 0.
    press(1, 0, 0, 0);
    chk("minimal_final", s, 4);

    // Wrap-around from face 0: 6 spin advances plus 4.
    do_reset();
    press(25, 0, 0, 0);
    chk("wrap_final", s, 2);

    // Randomized rolls, some with a re-grab.
    for (int i = 0; i < 8; i++) begin
      r  = $urandom_range(1, 40);
      g  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, TOTAL - 1) : 0;
      r2 = $urandom_range(1, 30);
      press(r, g, r2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
